// File: rtl/riscv_csr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_csr_pkg
//  Description : Shared machine-mode CSR addresses, trap cause codes,
//                mstatus field positions and the trap sequencer state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_csr_pkg;

    // Machine-mode CSR addresses
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    // Exception cause codes (mcause[XLEN-1] = 0)
    localparam logic [4:0] CAUSE_IADDR_MISALIGNED = 5'd0;
    localparam logic [4:0] CAUSE_LADDR_MISALIGNED = 5'd4;
    localparam logic [4:0] CAUSE_SADDR_MISALIGNED = 5'd5;

    // Interrupt codes (mcause[XLEN-1] = 1), also the mie/mip bit positions
    localparam logic [4:0] IRQ_MSI = 5'd3;
    localparam logic [4:0] IRQ_MTI = 5'd7;
    localparam logic [4:0] IRQ_MEI = 5'd11;

    // mstatus field positions
    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LSB  = 11;
    localparam int MSTATUS_MPP_MSB  = 12;

    // Trap sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAVE   = 2'd1,
        ST_VECTOR = 2'd2,
        ST_RET    = 2'd3
    } trap_state_t;

endpackage
`default_nettype wire

// File: rtl/irq_priority.sv
`default_nettype none
// ============================================================================
//  Module      : irq_priority
//  Description : Combinational machine interrupt selector.
//                Picks the highest-priority enabled-and-pending interrupt,
//                MEI(11) > MSI(3) > MTI(7); every other bit is ignored.
//  Ports       : i_pending [XLEN-1:0] - mie & mip
//                o_valid               - some supported interrupt is pending
//                o_code    [4:0]       - selected interrupt code
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_priority
    import riscv_csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_pending,
    output logic            o_valid,
    output logic [4:0]      o_code
);

    // Only three bits are architecturally meaningful here; fold the rest
    // into a sink so the full CSR width can be passed in unmodified.
    logic w_unused_pending;
    assign w_unused_pending = ^i_pending;

    always_comb begin
        o_valid = 1'b1;
        o_code  = 5'd0;
        if (i_pending[IRQ_MEI]) begin
            o_code = IRQ_MEI;
        end else if (i_pending[IRQ_MSI]) begin
            o_code = IRQ_MSI;
        end else if (i_pending[IRQ_MTI]) begin
            o_code = IRQ_MTI;
        end else begin
            o_valid = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/trap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : trap_sequencer
//  Description : Machine-mode trap responder. Commits mepc/mcause/mtval/
//                mstatus for exceptions and interrupts, redirects fetch to
//                mtvec, and executes MRET back to mepc.
//  Ports       : clk, resetn (sync, active low)
//                trap_req/cause/epc/tval - exception request, held to ack
//                mret                    - MRET retiring (pulse)
//                done, pc                - instruction boundary / next PC
//                mtvec, mie_reg, mip_reg - CSR inputs
//                csr_we/addr/wdata       - software CSR writes
//                mepc/mcause/mtval/mstatus - CSR outputs
//                pc_load/pc_new          - fetch redirect
//                trap_ack, busy          - handshake / fetch stall
//  Revision    : 1.0 - initial release
// ============================================================================
module trap_sequencer
    import riscv_csr_pkg::*;
#(
    parameter int         XLEN      = 32,
    parameter logic [1:0] MPP_RESET = 2'b11
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_epc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret,
    input  logic            done,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mie_reg,
    input  logic [XLEN-1:0] mip_reg,
    input  logic            csr_we,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] mcause,
    output logic [XLEN-1:0] mtval,
    output logic [XLEN-1:0] mstatus,
    output logic            pc_load,
    output logic [XLEN-1:0] pc_new,
    output logic            trap_ack,
    output logic            busy
);

    localparam logic [XLEN-1:0] c_align_mask = {{(XLEN-2){1'b1}}, 2'b00};

    trap_state_t     r_state, w_state_nxt;

    // Trap details captured on the IDLE->SAVE edge, committed at end of SAVE
    logic            r_cap_irq;
    logic [4:0]      r_cap_code;
    logic [XLEN-1:0] r_cap_epc, r_cap_cause, r_cap_tval;

    logic [XLEN-1:0] r_mepc, r_mcause, r_mtval, r_pc_new;
    logic            r_mie, r_mpie, r_pc_load, r_trap_ack;
    logic [1:0]      r_mpp;

    logic            w_irq_valid;
    logic [4:0]      w_irq_code;
    logic            w_take_exc, w_take_irq, w_take_ret;
    logic            w_pc_load_nxt, w_trap_ack_nxt;
    logic [XLEN-1:0] w_pc_new_nxt, w_vec_target;
    logic            w_wr_mstatus, w_wr_mepc, w_wr_mcause, w_wr_mtval;

    irq_priority #(
        .XLEN (XLEN)
    ) u_irq_priority (
        .i_pending (mie_reg & mip_reg),
        .o_valid   (w_irq_valid),
        .o_code    (w_irq_code)
    );

    // Vectored mode (01) offsets interrupts only; modes 1x behave as direct
    assign w_vec_target = (mtvec & c_align_mask) +
                          ((r_cap_irq && (mtvec[1:0] == 2'b01)) ?
                           {{(XLEN-7){1'b0}}, r_cap_code, 2'b00} : '0);

    assign w_wr_mstatus = csr_we && (csr_addr == CSR_MSTATUS);
    assign w_wr_mepc    = csr_we && (csr_addr == CSR_MEPC);
    assign w_wr_mcause  = csr_we && (csr_addr == CSR_MCAUSE);
    assign w_wr_mtval   = csr_we && (csr_addr == CSR_MTVAL);

    always_comb begin
        w_state_nxt    = r_state;
        w_take_exc     = 1'b0;
        w_take_irq     = 1'b0;
        w_take_ret     = 1'b0;
        w_pc_load_nxt  = 1'b0;
        w_trap_ack_nxt = 1'b0;
        w_pc_new_nxt   = r_pc_new;
        case (r_state)
            ST_IDLE: begin
                // Strict priority; losers in the same cycle are dropped
                if (trap_req) begin
                    w_take_exc  = 1'b1;
                    w_state_nxt = ST_SAVE;
                end else if (r_mie && done && w_irq_valid) begin
                    w_take_irq  = 1'b1;
                    w_state_nxt = ST_SAVE;
                end else if (mret) begin
                    w_take_ret    = 1'b1;
                    w_state_nxt   = ST_RET;
                    w_pc_load_nxt = 1'b1;
                    w_pc_new_nxt  = r_mepc;
                end
            end
            ST_SAVE: begin
                w_state_nxt    = ST_VECTOR;
                w_pc_load_nxt  = 1'b1;
                w_trap_ack_nxt = 1'b1;
                w_pc_new_nxt   = w_vec_target;
            end
            ST_VECTOR: w_state_nxt = ST_IDLE;
            ST_RET:    w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_cap_irq   <= 1'b0;
            r_cap_code  <= 5'd0;
            r_cap_epc   <= '0;
            r_cap_cause <= '0;
            r_cap_tval  <= '0;
            r_mepc      <= '0;
            r_mcause    <= '0;
            r_mtval     <= '0;
            r_mie       <= 1'b0;
            r_mpie      <= 1'b0;
            r_mpp       <= MPP_RESET;
            r_pc_new    <= '0;
            r_pc_load   <= 1'b0;
            r_trap_ack  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc_load  <= w_pc_load_nxt;
            r_trap_ack <= w_trap_ack_nxt;
            r_pc_new   <= w_pc_new_nxt;

            if (w_take_exc) begin
                r_cap_irq   <= 1'b0;
                r_cap_code  <= 5'd0;
                r_cap_epc   <= trap_epc & c_align_mask;
                r_cap_cause <= trap_cause;
                r_cap_tval  <= trap_tval;
            end else if (w_take_irq) begin
                r_cap_irq   <= 1'b1;
                r_cap_code  <= w_irq_code;
                r_cap_epc   <= pc & c_align_mask;
                r_cap_cause <= {1'b1, {(XLEN-6){1'b0}}, w_irq_code};
                r_cap_tval  <= '0;
            end

            // Hardware commit in SAVE beats a coincident software write
            if (r_state == ST_SAVE) begin
                r_mepc   <= r_cap_epc;
                r_mcause <= r_cap_cause;
                r_mtval  <= r_cap_tval;
            end else begin
                if (w_wr_mepc)   r_mepc   <= csr_wdata & c_align_mask;
                if (w_wr_mcause) r_mcause <= csr_wdata;
                if (w_wr_mtval)  r_mtval  <= csr_wdata;
            end

            if (r_state == ST_SAVE) begin
                r_mpie <= r_mie;
                r_mie  <= 1'b0;
                r_mpp  <= 2'b11;
            end else if (r_state == ST_RET) begin
                r_mie  <= r_mpie;
                r_mpie <= 1'b1;
                r_mpp  <= MPP_RESET;
            end else if (w_wr_mstatus) begin
                r_mie  <= csr_wdata[MSTATUS_MIE_BIT];
                r_mpie <= csr_wdata[MSTATUS_MPIE_BIT];
                r_mpp  <= csr_wdata[MSTATUS_MPP_MSB:MSTATUS_MPP_LSB];
            end
        end
    end

    assign mepc     = r_mepc;
    assign mcause   = r_mcause;
    assign mtval    = r_mtval;
    assign mstatus  = {{(XLEN-13){1'b0}}, r_mpp, 3'b000, r_mpie, 3'b000, r_mie, 3'b000};
    assign pc_load  = r_pc_load;
    assign pc_new   = r_pc_new;
    assign trap_ack = r_trap_ack;
    assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_trap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trap_sequencer
//  Description : Self-checking bench for trap_sequencer. A CSR write table,
//                directed trap/MRET/collision/gating sequences, then random
//                events against an architectural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        resetn, trap_req, mret, done, csr_we;
    logic [31:0] trap_cause, trap_epc, trap_tval, pc, mtvec, mie_reg, mip_reg, csr_wdata;
    logic [11:0] csr_addr;
    logic [31:0] mepc, mcause, mtval, mstatus, pc_new;
    logic        pc_load, trap_ack, busy;

    trap_sequencer #(
        .XLEN      (32),
        .MPP_RESET (2'b11)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .trap_req   (trap_req),
        .trap_cause (trap_cause),
        .trap_epc   (trap_epc),
        .trap_tval  (trap_tval),
        .mret       (mret),
        .done       (done),
        .pc         (pc),
        .mtvec      (mtvec),
        .mie_reg    (mie_reg),
        .mip_reg    (mip_reg),
        .csr_we     (csr_we),
        .csr_addr   (csr_addr),
        .csr_wdata  (csr_wdata),
        .mepc       (mepc),
        .mcause     (mcause),
        .mtval      (mtval),
        .mstatus    (mstatus),
        .pc_load    (pc_load),
        .pc_new     (pc_new),
        .trap_ack   (trap_ack),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Architectural reference state
    logic [31:0] m_mepc, m_mcause, m_mtval;
    logic        m_mie, m_mpie;
    logic [1:0]  m_mpp;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        logic [31:0] e_ms;
        logic [31:0] e_epc;
        logic [31:0] e_cause;
        logic [31:0] e_tval;
    } csr_vec_t;

    csr_vec_t tbl [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_mstatus();
        return {19'b0, m_mpp, 3'b000, m_mpie, 3'b000, m_mie, 3'b000};
    endfunction

    // Highest-priority supported interrupt, or -1 when none
    function automatic int pick_irq(input logic [31:0] pend);
        int order [3];
        order = '{11, 3, 7};
        for (int i = 0; i < 3; i++)
            if (pend[order[i]]) return order[i];
        return -1;
    endfunction

    task automatic check_csrs(input string nm);
        chk($sformatf("%s.mepc", nm),    mepc,    m_mepc);
        chk($sformatf("%s.mcause", nm),  mcause,  m_mcause);
        chk($sformatf("%s.mtval", nm),   mtval,   m_mtval);
        chk($sformatf("%s.mstatus", nm), mstatus, model_mstatus());
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csr_we = 1'b1; csr_addr = a; csr_wdata = d;
        step();
        csr_we = 1'b0;
        case (a)
            12'h300: begin m_mie = d[3]; m_mpie = d[7]; m_mpp = d[12:11]; end
            12'h341: m_mepc   = d & ~32'h3;
            12'h342: m_mcause = d;
            12'h343: m_mtval  = d;
            default: ;
        endcase
    endtask

    // Presents one IDLE-cycle event and watches the following four cycles.
    task automatic run_event(input string nm, input logic t_req, input logic [31:0] cause,
                             input logic [31:0] epc, input logic [31:0] tval, input logic m_ret,
                             input logic dn, input logic [31:0] pcv, input logic [31:0] tvec,
                             input logic [31:0] ie, input logic [31:0] ip, input logic save_wr);
        int          code, kind;
        logic [4:0]  e_load, e_ack, e_busy, o_load, o_ack, o_busy;
        logic [31:0] e_pcnew, o_pcnew;
        code = pick_irq(ie & ip);
        if (t_req)                         kind = 1;
        else if (m_mie && dn && code >= 0) kind = 2;
        else if (m_ret)                    kind = 3;
        else                               kind = 0;
        e_pcnew = 32'h0; e_load = 5'b0; e_ack = 5'b0; e_busy = 5'b0;
        if (kind == 1 || kind == 2) begin
            e_load = 5'b00100; e_ack = 5'b00100; e_busy = 5'b00110;
            e_pcnew = (tvec & ~32'h3) +
                      ((kind == 2 && tvec[1:0] == 2'b01) ? 32'(code * 4) : 32'h0);
        end else if (kind == 3) begin
            e_load = 5'b00010; e_busy = 5'b00010;
            e_pcnew = m_mepc;
        end

        trap_req = t_req; trap_cause = cause; trap_epc = epc; trap_tval = tval;
        mret = m_ret; done = dn; pc = pcv; mtvec = tvec; mie_reg = ie; mip_reg = ip;
        o_load = 5'b0; o_ack = 5'b0; o_busy = 5'b0; o_pcnew = 32'h0;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 1) begin
                mret = 1'b0; mie_reg = 32'h0; mip_reg = 32'h0;
                if (save_wr) begin
                    csr_we = 1'b1; csr_addr = 12'h341; csr_wdata = 32'hDEAD_BEE0;
                end
            end
            if (k == 2) csr_we = 1'b0;
            o_load[k] = pc_load; o_ack[k] = trap_ack; o_busy[k] = busy;
            if (pc_load) o_pcnew = pc_new;
            if (trap_ack || k == 3) trap_req = 1'b0;
        end

        if (kind == 1) begin
            m_mepc = epc & ~32'h3; m_mcause = cause; m_mtval = tval;
        end else if (kind == 2) begin
            m_mepc = pcv & ~32'h3; m_mcause = 32'h8000_0000 | 32'(code); m_mtval = 32'h0;
        end
        if (kind == 1 || kind == 2) begin
            m_mpie = m_mie; m_mie = 1'b0; m_mpp = 2'b11;
        end else if (kind == 3) begin
            m_mie = m_mpie; m_mpie = 1'b1; m_mpp = 2'b11;
        end

        chk($sformatf("%s.load_timing", nm), {27'b0, o_load}, {27'b0, e_load});
        chk($sformatf("%s.ack_timing", nm),  {27'b0, o_ack},  {27'b0, e_ack});
        chk($sformatf("%s.busy_timing", nm), {27'b0, o_busy}, {27'b0, e_busy});
        if (kind != 0) chk($sformatf("%s.pc_new", nm), o_pcnew, e_pcnew);
        check_csrs(nm);
    endtask

    initial begin
        int loads;
        resetn = 1'b0; trap_req = 1'b1; trap_cause = 32'h5; trap_epc = 32'h1234;
        trap_tval = 32'h99; mret = 1'b0; done = 1'b1; pc = 32'h0; mtvec = 32'h100;
        mie_reg = 32'h0; mip_reg = 32'h0; csr_we = 1'b0; csr_addr = 12'h0; csr_wdata = 32'h0;

        // Reset overrides a pending trap request
        repeat (3) step();
        chk("rst.mepc", mepc, 32'h0);
        chk("rst.mcause", mcause, 32'h0);
        chk("rst.mtval", mtval, 32'h0);
        chk("rst.pc_new", pc_new, 32'h0);
        chk("rst.pc_load", {31'b0, pc_load}, 32'h0);
        chk("rst.trap_ack", {31'b0, trap_ack}, 32'h0);
        chk("rst.busy", {31'b0, busy}, 32'h0);
        chk("rst.mstatus", mstatus, 32'h0000_1800);

        m_mepc = 32'h0; m_mcause = 32'h0; m_mtval = 32'h0;
        m_mie = 1'b0; m_mpie = 1'b0; m_mpp = 2'b11;

        // Release with trap_req still high: taken on the first cycle out of reset
        resetn = 1'b1;
        run_event("rst_release", 1'b1, 32'h0, 32'h13, 32'h77, 1'b0, 1'b0, 32'h0,
                  32'h80, 32'h0, 32'h0, 1'b0);

        // CSR write table
        tbl[0] = '{12'h341, 32'h0000_1235, 32'h1800, 32'h1234, 32'h0,         32'h77};
        tbl[1] = '{12'h342, 32'hA5A5_0004, 32'h1800, 32'h1234, 32'hA5A5_0004, 32'h77};
        tbl[2] = '{12'h343, 32'hFFFF_FFFF, 32'h1800, 32'h1234, 32'hA5A5_0004, 32'hFFFF_FFFF};
        tbl[3] = '{12'h300, 32'hFFFF_FFFF, 32'h1888, 32'h1234, 32'hA5A5_0004, 32'hFFFF_FFFF};
        tbl[4] = '{12'h300, 32'h0000_0080, 32'h0080, 32'h1234, 32'hA5A5_0004, 32'hFFFF_FFFF};
        tbl[5] = '{12'h344, 32'h0000_1111, 32'h0080, 32'h1234, 32'hA5A5_0004, 32'hFFFF_FFFF};
        tbl[6] = '{12'h300, 32'h0000_1808, 32'h1808, 32'h1234, 32'hA5A5_0004, 32'hFFFF_FFFF};
        for (int i = 0; i < 7; i++) begin
            csr_write(tbl[i].addr, tbl[i].data);
            chk($sformatf("tbl%0d.mstatus", i), mstatus, tbl[i].e_ms);
            chk($sformatf("tbl%0d.mepc", i),    mepc,    tbl[i].e_epc);
            chk($sformatf("tbl%0d.mcause", i),  mcause,  tbl[i].e_cause);
            chk($sformatf("tbl%0d.mtval", i),   mtval,   tbl[i].e_tval);
        end

        // Store-misaligned exception, direct vector
        run_event("exc", 1'b1, 32'h5, 32'h2004, 32'h2003, 1'b0, 1'b0, 32'h0,
                  32'h100, 32'h0, 32'h0, 1'b0);
        chk("exc.mstatus_const", mstatus, 32'h0000_1880);

        // MRET back to 0x2004
        run_event("mret", 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,
                  32'h100, 32'h0, 32'h0, 1'b0);
        chk("mret.mstatus_const", mstatus, 32'h0000_1888);

        // Vectored MEI beats MTI
        run_event("virq", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h40,
                  32'h201, 32'h880, 32'h880, 1'b0);
        chk("virq.mcause_const", mcause, 32'h8000_000B);
        chk("virq.mepc_const", mepc, 32'h40);

        // trap_req and mret together: trap only
        run_event("coll_mret", 1'b1, 32'h4, 32'h300, 32'h301, 1'b1, 1'b0, 32'h0,
                  32'h400, 32'h0, 32'h0, 1'b0);

        // Software mepc write during SAVE loses
        run_event("save_wr", 1'b1, 32'h0, 32'h500, 32'h0, 1'b0, 1'b0, 32'h0,
                  32'h400, 32'h0, 32'h0, 1'b1);
        chk("save_wr.mepc_const", mepc, 32'h500);

        // Gating: done=0 with MIE=1, then MIE=0 with done=1
        csr_write(12'h300, 32'h1808);
        mie_reg = 32'h80; mip_reg = 32'h80; done = 1'b0; loads = 0;
        for (int i = 0; i < 10; i++) begin step(); loads += int'(pc_load); end
        chk("gate_done0.loads", 32'(loads), 32'h0);
        mie_reg = 32'h0; mip_reg = 32'h0;
        csr_write(12'h300, 32'h1800);
        mie_reg = 32'h80; mip_reg = 32'h80; done = 1'b1; loads = 0;
        for (int i = 0; i < 10; i++) begin step(); loads += int'(pc_load); end
        chk("gate_mie0.loads", 32'(loads), 32'h0);
        mie_reg = 32'h0; mip_reg = 32'h0;
        csr_write(12'h300, 32'h1808);
        run_event("gate_open", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h84,
                  32'h201, 32'h80, 32'h80, 1'b0);

        // Random events against the reference model
        for (int t = 0; t < 200; t++) begin
            logic [11:0] a;
            if ($urandom_range(0, 99) < 25) begin
                case ($urandom_range(0, 4))
                    0: a = 12'h300;
                    1: a = 12'h341;
                    2: a = 12'h342;
                    3: a = 12'h343;
                    default: a = 12'h344;
                endcase
                csr_write(a, $urandom);
                check_csrs("rnd_csr");
            end else begin
                run_event("rnd_evt", ($urandom_range(0, 3) == 0), $urandom, $urandom,
                          $urandom, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0),
                          $urandom, $urandom, $urandom, $urandom, 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
